// File: rtl/bcd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_pkg : shared types and sizing helper for the sequential BCD converter
// Rev 1.0
// ----------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   // Decimal digits needed to represent the largest bin_w-bit unsigned value.
   function automatic int bcd_min_digits(input int bin_w);
      longint unsigned max_val;
      int              n;
      max_val = (64'd1 << bin_w) - 64'd1;
      n = 1;
      while (max_val >= 64'd10) begin
         max_val = max_val / 64'd10;
         n = n + 1;
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_dabble_step : one add-3-then-shift iteration on the {bcd, bin} work reg
// Rev 1.0
// ----------------------------------------------------------------------------
module bcd_dabble_step
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] work_in,
   output logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] work_out
);

   localparam int WORK_W = BCD_DIGIT_W*DIGITS + BIN_W;

   logic [WORK_W-1:0] adjusted;

   // Digits are corrected independently; the sizing check guarantees no carry out.
   always_comb begin
      adjusted = work_in;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_in[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] >= 4'd5) begin
            adjusted[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] =
               work_in[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] + 4'd3;
         end
      end
   end

   assign work_out = adjusted << 1;

endmodule
`default_nettype wire

// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_seq_conv : iterative binary-to-BCD converter, one bit per clock, valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BIN_W-1:0]              in_bin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]             digit_sig
);

   localparam int BCD_W  = BCD_DIGIT_W*DIGITS;
   localparam int WORK_W = BCD_W + BIN_W;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   generate
      if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
         $error("bcd_seq_conv: BIN_W must be in 1..32");
      end
      if (DIGITS < bcd_min_digits(BIN_W)) begin : g_too_few_digits
         $error("bcd_seq_conv: DIGITS too small to hold 2**BIN_W-1");
      end
   endgenerate

   bcd_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [WORK_W-1:0] work;
   logic [WORK_W-1:0] step_out;
   logic [BCD_W-1:0]  step_bcd;
   logic [DIGITS-1:0] next_sig;
   logic              sig_seen;

   bcd_dabble_step #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_step (
      .work_in  (work),
      .work_out (step_out)
   );

   assign step_bcd = step_out[WORK_W-1 -: BCD_W];
   assign in_ready = (state == IDLE);

   // A digit is significant once any digit at or above it is nonzero.
   always_comb begin
      sig_seen = 1'b0;
      next_sig = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         sig_seen    = sig_seen | (step_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W] != '0);
         next_sig[i] = sig_seen;
      end
      next_sig[0] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         work      <= '0;
         bcd_out   <= '0;
         digit_sig <= DIGITS'(1);
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work  <= {{BCD_W{1'b0}}, in_bin};
                  cnt   <= CNT_LAST;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               work <= step_out;
               if (cnt == '0) begin
                  bcd_out   <= step_bcd;
                  digit_sig <= next_sig;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
